bram_capture_sequencer: RTL and testbench
=========================================

Name: bram_capture_sequencer

Overview:
Next-generation BRAM address/write-enable generator for triggered acquisition, replacing the free-running counter.
- Adds software arm, a pre-trigger window kept in a circular buffer, a programmable post-trigger length, and trigger edge select.
- Adds single-shot or continuous re-arm, a done flag, and the trigger address for readout.
- Sits between the ADC sample stream (clken per sample) and a BRAM write port; software reads the buffer from trig_addr minus the pre-trigger length.

Parameters:
COUNT_WIDTH, 13, width of sample counter; buffer depth up to 2^COUNT_WIDTH words
BYTES_PER_WORD, 4, BRAM byte lanes; width of wen, address shift = log2(BYTES_PER_WORD)
ADDR_WIDTH, 32, width of byte address output

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
clken  in  1  sample valid; one BRAM word per clken cycle
trig  in  1  raw trigger level
start  in  1  arm request, level sampled each cycle
continuous  in  1  1 = auto re-arm after capture
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge
count_max  in  COUNT_WIDTH  last buffer index; depth = count_max+1
pretrig_len  in  COUNT_WIDTH  samples written before trigger is accepted
post_len  in  COUNT_WIDTH  samples written from trigger sample inclusive
address  out  ADDR_WIDTH  byte address = count << log2(BYTES_PER_WORD)
wen  out  BYTES_PER_WORD  all lanes equal
busy  out  1  high in PRETRIG/ARMED/CAPTURE
done  out  1  high in DONE
trig_addr  out  ADDR_WIDTH  byte address of the trigger sample

Behaviour:
- Reset: state IDLE; count=0, address=0, wen=0, busy=0, done=0, trig_addr=0, edge pending=0, trig_reg=0.
- Config latch: count_max, pretrig_len, post_len and trig_falling are latched on the cycle start is accepted; later changes have no effect until the next arm.
- Edge detect: trig_reg <= trig every cycle.
  - Rising edge = trig & ~trig_reg; falling edge = ~trig & trig_reg.
  - A detected edge sets pending. Pending is cleared in every state except ARMED.
- Sample write: on each clken cycle in PRETRIG/ARMED/CAPTURE:
  - the next cycle drives wen=all-ones and address=count;
  - count then advances, wrapping count_max -> 0.
  - Non-clken cycles drive wen=0. Latency from the clken cycle to the wen/address output is 1 cycle, registered.
- IDLE: wen=0. start=1 -> count=0, sample counter=0; go to PRETRIG, or to ARMED if pretrig_len=0.
- PRETRIG: writes samples and counts clken cycles. After pretrig_len writes go to ARMED. Triggers are ignored.
- ARMED: writes circularly. On a clken cycle with pending=1 (or an edge in the same cycle):
  - that sample is the trigger sample;
  - trig_addr <= its byte address;
  - post counter = 1; go to CAPTURE, or to DONE if effective post_len=1.
- CAPTURE: writes until post_len samples total, counting the trigger sample, then goes to DONE.
- post_len=0 is treated as 1. pretrig_len > count_max is clamped to count_max.
- DONE: wen=0; done=1; count and trig_addr held.
  - continuous=1, or start=1 -> re-arm exactly as from IDLE on the next cycle.
  - Otherwise go to IDLE when start=0 and continuous=0. done stays high until leaving DONE.
- Simultaneous events:
  - start while busy is ignored.
  - An edge on the cycle PRETRIG completes is discarded.
  - An edge on the same clken cycle as the ARMED entry write is not accepted; the trigger needs a cycle already in ARMED.
- rst mid-capture: immediate IDLE next cycle; wen=0 that cycle; no partial done.
- Widths:
  - address is zero-extended count shifted; the upper bits beyond COUNT_WIDTH+log2(BYTES_PER_WORD) are 0.
  - Counters are COUNT_WIDTH wide with explicit wrap.

Optional Feature:
Macro BRAM_CAPTURE_DECIMATION_EN.
- Enabled: adds input decim (16 bits). Writes occur only on every (decim+1)-th clken cycle.
  - The decimation counter resets on arm.
  - Triggers are evaluated only on decimated write cycles; pending holds meanwhile.
  - decim=0 behaves identically to the feature being disabled.
- Disabled: port absent; every clken cycle is a write cycle.

Test Plan:
- Basic single shot: count_max=15, pretrig_len=4, post_len=8, clken=1, start pulse, rising trig after 10 cycles in ARMED -> exactly 4+10+8 wen cycles; trig_addr=((4+10)%16)<<2=56; done=1; then IDLE after start=0.
- Falling edge and clken gaps: trig_falling=1, clken toggling 1/0, trig falls on a clken=0 cycle -> pending consumed on the next clken; trig_addr is that sample's address; no wen on clken=0 cycles.
- Pre-trigger ignore and zero lengths: pretrig_len=8 with trig pulses during PRETRIG -> not accepted; then pretrig_len=0, post_len=0 -> ARMED immediately, one write on trigger, then DONE.
- Continuous mode: continuous=1, three triggers -> three done pulses; each re-arm restarts at count=0; 0 writes in DONE cycles.
- Reset and start-while-busy: start during CAPTURE ignored; rst asserted mid-CAPTURE -> next cycle wen=0, address=0, busy=0, done=0, trig_addr=0.
- Wrap: count_max=3, pretrig_len=3, post_len=6 -> addresses 0,4,8,12,0,4,... with no write beyond index 3.

Source files
------------

// File: rtl/bram_capture_sequencer.sv
// Triggered-acquisition BRAM write sequencer.
// Generates BRAM word writes into a circular buffer: an optional pre-trigger
// fill, an armed phase waiting for a trigger edge, and a fixed post-trigger
// length. The trigger sample's byte address is reported for readout.
// Optional build macro BRAM_CAPTURE_DECIMATION_EN adds i_decim: only every
// (i_decim+1)-th clken cycle is treated as a sample write.
module bram_capture_sequencer #(
  parameter int COUNT_WIDTH    = 13,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clken,
  input  logic                      i_trig,
  input  logic                      i_start,
  input  logic                      i_continuous,
  input  logic                      i_trig_falling,
  input  logic [COUNT_WIDTH-1:0]    i_count_max,
  input  logic [COUNT_WIDTH-1:0]    i_pretrig_len,
  input  logic [COUNT_WIDTH-1:0]    i_post_len,
`ifdef BRAM_CAPTURE_DECIMATION_EN
  input  logic [15:0]               i_decim,
`endif
  output logic [ADDR_WIDTH-1:0]     o_address,
  output logic [BYTES_PER_WORD-1:0] o_wen,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [ADDR_WIDTH-1:0]     o_trig_addr
);

  localparam int SHIFT = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [COUNT_WIDTH-1:0]    r_count;      // buffer write index
  logic [COUNT_WIDTH-1:0]    r_cnt;        // pre-trigger / post-trigger sample counter
  logic [COUNT_WIDTH-1:0]    r_count_max;
  logic [COUNT_WIDTH-1:0]    r_pre_len;    // already clamped to count_max
  logic [COUNT_WIDTH-1:0]    r_post_len;   // already forced to at least 1
  logic                      r_falling;
  logic                      r_trig_reg;
  logic                      r_pending;
  logic [ADDR_WIDTH-1:0]     r_address;
  logic [ADDR_WIDTH-1:0]     r_trig_addr;
  logic [BYTES_PER_WORD-1:0] r_wen;
  logic                      r_busy;
  logic                      r_done;
`ifdef BRAM_CAPTURE_DECIMATION_EN
  logic [15:0]               r_decim_cnt;
`endif

  logic                      w_edge;
  logic                      w_active;
  logic                      w_tick;
  logic                      w_wr;
  logic                      w_arm;
  logic [COUNT_WIDTH-1:0]    w_count_nxt;
  logic [COUNT_WIDTH-1:0]    w_cnt_nxt;
  logic [COUNT_WIDTH-1:0]    w_pre_eff;
  logic [COUNT_WIDTH-1:0]    w_post_eff;
  logic [ADDR_WIDTH-1:0]     w_addr_cur;

  // Edge detection uses the edge polarity latched at arm time.
  assign w_edge = r_falling ? (~i_trig & r_trig_reg) : (i_trig & ~r_trig_reg);

  assign w_active = (r_state == S_PRETRIG) || (r_state == S_ARMED) ||
                    (r_state == S_CAPTURE);

`ifdef BRAM_CAPTURE_DECIMATION_EN
  assign w_tick = i_clken && (r_decim_cnt == i_decim);
`else
  assign w_tick = i_clken;
`endif

  assign w_wr        = w_active && w_tick;
  assign w_arm       = ((r_state == S_IDLE) && i_start) ||
                       ((r_state == S_DONE) && (i_start || i_continuous));
  assign w_count_nxt = (r_count == r_count_max) ? '0 : r_count + 1'b1;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_pre_eff   = (i_pretrig_len > i_count_max) ? i_count_max : i_pretrig_len;
  assign w_post_eff  = (i_post_len == '0) ? COUNT_WIDTH'(1) : i_post_len;
  assign w_addr_cur  = ADDR_WIDTH'(r_count) << SHIFT;

`ifdef BRAM_CAPTURE_DECIMATION_EN
  // Decimation phase: restarts on every arm, advances on active clken cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_arm)
      r_decim_cnt <= '0;
    else if (w_active && i_clken)
      r_decim_cnt <= (r_decim_cnt == i_decim) ? 16'd0 : r_decim_cnt + 16'd1;
  end
`endif

  // Capture FSM with registered BRAM port, status and trigger bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_cnt       <= '0;
      r_count_max <= '0;
      r_pre_len   <= '0;
      r_post_len  <= COUNT_WIDTH'(1);
      r_falling   <= 1'b0;
      r_trig_reg  <= 1'b0;
      r_pending   <= 1'b0;
      r_address   <= '0;
      r_trig_addr <= '0;
      r_wen       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_trig_reg <= i_trig;
      r_wen      <= w_wr ? '1 : '0;
      r_pending  <= 1'b0;
      if (w_wr) begin
        r_address <= w_addr_cur;
        r_count   <= w_count_nxt;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm) begin
            r_count_max <= i_count_max;
            r_pre_len   <= w_pre_eff;
            r_post_len  <= w_post_eff;
            r_falling   <= i_trig_falling;
            r_count     <= '0;
            r_cnt       <= '0;
            r_state     <= (w_pre_eff == '0) ? S_ARMED : S_PRETRIG;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end

        // Triggers are ignored; pending stays clear, including on the final write.
        S_PRETRIG: begin
          if (w_wr) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_pre_len)
              r_state <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (w_wr && (r_pending || w_edge)) begin
            r_trig_addr <= w_addr_cur;
            r_cnt       <= COUNT_WIDTH'(1);
            if (r_post_len == COUNT_WIDTH'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CAPTURE;
            end
          end else if (!w_wr) begin
            r_pending <= r_pending | w_edge;
          end
        end

        S_CAPTURE: begin
          if (w_wr) begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_post_len) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_address   = r_address;
  assign o_wen       = r_wen;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_trig_addr = r_trig_addr;

endmodule

// File: tb/tb_bram_capture_sequencer.sv
// Directed self-checking bench for bram_capture_sequencer.
module tb_bram_capture_sequencer;
  localparam int CW  = 13;
  localparam int BPW = 4;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          rst, clken, trig, start, continuous, trig_falling;
  logic [CW-1:0] count_max, pretrig_len, post_len;
`ifdef BRAM_CAPTURE_DECIMATION_EN
  logic [15:0]   decim = 16'd0;
`endif
  logic [AW-1:0]  address, trig_addr;
  logic [BPW-1:0] wen;
  logic           busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_cnt  = 0;
  int done_pulses = 0;
  logic done_d = 1'b0;
  logic [AW-1:0] addr_q[$];

  bram_capture_sequencer #(.COUNT_WIDTH(CW), .BYTES_PER_WORD(BPW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_clken(clken), .i_trig(trig), .i_start(start),
    .i_continuous(continuous), .i_trig_falling(trig_falling),
    .i_count_max(count_max), .i_pretrig_len(pretrig_len), .i_post_len(post_len),
`ifdef BRAM_CAPTURE_DECIMATION_EN
    .i_decim(decim),
`endif
    .o_address(address), .o_wen(wen), .o_busy(busy), .o_done(done),
    .o_trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  // Observer: counts writes, logs write addresses, counts done pulses.
  always @(negedge clk) begin
    if (wen != '0) begin
      wen_cnt = wen_cnt + 1;
      addr_q.push_back(address);
    end
    if (done && !done_d) done_pulses = done_pulses + 1;
    done_d = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clken = 1'b1; trig = 1'b1; start = 1'b1; continuous = 1'b0;
    trig_falling = 1'b0; count_max = 15; pretrig_len = 4; post_len = 8;
    step(); step();
    n_checks++; if (wen !== 4'h0) begin n_fail++; $display("FAIL reset_wen got %h exp 0", wen); end
    n_checks++; if (address !== 32'd0) begin n_fail++; $display("FAIL reset_address got %0d exp 0", address); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (trig_addr !== 32'd0) begin n_fail++; $display("FAIL reset_trig_addr got %0d exp 0", trig_addr); end
    rst = 1'b0; start = 1'b0; trig = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    int base;
    count_max = 15; pretrig_len = 4; post_len = 8; clken = 1'b1;
    trig_falling = 1'b0; continuous = 1'b0; trig = 1'b0;
    base = wen_cnt;
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_arm got %b exp 1", busy); end
    repeat (14) step();
    trig = 1'b1; step();
    n_checks++; if (address !== 32'd56) begin n_fail++; $display("FAIL basic_trig_write_addr got %0d exp 56", address); end
    n_checks++; if (trig_addr !== 32'd56) begin n_fail++; $display("FAIL basic_trig_addr got %0d exp 56", trig_addr); end
    repeat (7) step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got %b exp 0", busy); end
    n_checks++; if (address !== 32'd20) begin n_fail++; $display("FAIL basic_last_addr got %0d exp 20", address); end
    trig = 1'b0; step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_idle_done got %b exp 0", done); end
    n_checks++; if (wen !== 4'h0) begin n_fail++; $display("FAIL basic_idle_wen got %h exp 0", wen); end
    n_checks++; if (wen_cnt - base !== 22) begin n_fail++; $display("FAIL basic_wen_count got %0d exp 22", wen_cnt - base); end
  endtask

  task automatic test_falling_gaps();
    int base;
    count_max = 15; pretrig_len = 0; post_len = 2; trig_falling = 1'b1;
    trig = 1'b1; clken = 1'b0; continuous = 1'b0;
    step();
    base = wen_cnt;
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fall_armed_busy got %b exp 1", busy); end
    clken = 1'b1; step();
    n_checks++; if (wen !== 4'hF) begin n_fail++; $display("FAIL fall_first_wen got %h exp f", wen); end
    clken = 1'b0; trig = 1'b0; step();
    n_checks++; if (wen !== 4'h0) begin n_fail++; $display("FAIL fall_gap_wen got %h exp 0", wen); end
    clken = 1'b1; step();
    n_checks++; if (address !== 32'd4) begin n_fail++; $display("FAIL fall_trig_write_addr got %0d exp 4", address); end
    n_checks++; if (trig_addr !== 32'd4) begin n_fail++; $display("FAIL fall_trig_addr got %0d exp 4", trig_addr); end
    clken = 1'b0; step();
    n_checks++; if (wen !== 4'h0) begin n_fail++; $display("FAIL fall_gap2_wen got %h exp 0", wen); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fall_capture_busy got %b exp 1", busy); end
    clken = 1'b1; step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fall_done got %b exp 1", done); end
    n_checks++; if (address !== 32'd8) begin n_fail++; $display("FAIL fall_last_addr got %0d exp 8", address); end
    clken = 1'b0; step();
    n_checks++; if (wen_cnt - base !== 3) begin n_fail++; $display("FAIL fall_wen_count got %0d exp 3", wen_cnt - base); end
    trig_falling = 1'b0;
  endtask

  task automatic test_pretrig_zero();
    int base;
    logic [3:0] pat;
    count_max = 15; pretrig_len = 8; post_len = 1; clken = 1'b1; trig = 1'b0;
    pat = 4'b0000;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pat = 4'(i);
      trig = pat[0];
      step();
    end
    trig = 1'b0; repeat (3) step();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_ignored_busy got %b exp 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL pre_ignored_done got %b exp 0", done); end
    n_checks++; if (address !== 32'd40) begin n_fail++; $display("FAIL pre_armed_addr got %0d exp 40", address); end
    trig = 1'b1; step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pre_done got %b exp 1", done); end
    n_checks++; if (trig_addr !== 32'd44) begin n_fail++; $display("FAIL pre_trig_addr got %0d exp 44", trig_addr); end
    trig = 1'b0; step();
    pretrig_len = 0; post_len = 0;
    base = wen_cnt;
    start = 1'b1; step(); start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_armed_busy got %b exp 1", busy); end
    step();
    trig = 1'b1; step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", done); end
    n_checks++; if (trig_addr !== 32'd4) begin n_fail++; $display("FAIL zero_trig_addr got %0d exp 4", trig_addr); end
    trig = 1'b0; step();
    n_checks++; if (wen_cnt - base !== 2) begin n_fail++; $display("FAIL zero_wen_count got %0d exp 2", wen_cnt - base); end
  endtask

  task automatic test_continuous();
    int base, dp0;
    count_max = 7; pretrig_len = 2; post_len = 2; continuous = 1'b1;
    clken = 1'b1; trig = 1'b0;
    base = wen_cnt; dp0 = done_pulses;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (address !== 32'd0) begin n_fail++; $display("FAIL cont_restart_addr k=%0d got %0d exp 0", k, address); end
      step(); step();
      trig = 1'b1; step();
      n_checks++; if (trig_addr !== 32'd12) begin n_fail++; $display("FAIL cont_trig_addr k=%0d got %0d exp 12", k, trig_addr); end
      trig = 1'b0; step();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cont_done k=%0d got %b exp 1", k, done); end
      if (k == 2) continuous = 1'b0;
      step();
      n_checks++; if (wen !== 4'h0) begin n_fail++; $display("FAIL cont_done_wen k=%0d got %h exp 0", k, wen); end
      n_checks++; if (busy !== (k < 2)) begin n_fail++; $display("FAIL cont_rearm_busy k=%0d got %b exp %b", k, busy, (k < 2)); end
    end
    step();
    n_checks++; if (done_pulses - dp0 !== 3) begin n_fail++; $display("FAIL cont_done_pulses got %0d exp 3", done_pulses - dp0); end
    n_checks++; if (wen_cnt - base !== 15) begin n_fail++; $display("FAIL cont_wen_count got %0d exp 15", wen_cnt - base); end
  endtask

  task automatic test_reset_busy();
    count_max = 15; pretrig_len = 0; post_len = 8; continuous = 1'b0;
    clken = 1'b1; trig = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    trig = 1'b1; step();
    n_checks++; if (trig_addr !== 32'd8) begin n_fail++; $display("FAIL rb_trig_addr got %0d exp 8", trig_addr); end
    start = 1'b1; post_len = 3; pretrig_len = 5;
    step(); step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rb_start_ignored_busy got %b exp 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rb_start_ignored_done got %b exp 0", done); end
    n_checks++; if (address !== 32'd16) begin n_fail++; $display("FAIL rb_capture_addr got %0d exp 16", address); end
    step();
    rst = 1'b1; step();
    n_checks++; if (wen !== 4'h0) begin n_fail++; $display("FAIL rb_rst_wen got %h exp 0", wen); end
    n_checks++; if (address !== 32'd0) begin n_fail++; $display("FAIL rb_rst_address got %0d exp 0", address); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rb_rst_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rb_rst_done got %b exp 0", done); end
    n_checks++; if (trig_addr !== 32'd0) begin n_fail++; $display("FAIL rb_rst_trig_addr got %0d exp 0", trig_addr); end
    rst = 1'b0; trig = 1'b0; step();
    n_checks++; if (wen !== 4'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rb_after_rst got wen=%h busy=%b exp wen=0 busy=0", wen, busy); end
  endtask

  task automatic test_wrap();
    int qb;
    logic [AW-1:0] exp_a [9];
    exp_a = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd4, 32'd8, 32'd12, 32'd0};
    count_max = 3; pretrig_len = 3; post_len = 6; continuous = 1'b0;
    clken = 1'b1; trig = 1'b0;
    qb = addr_q.size();
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    trig = 1'b1; step();
    trig = 1'b0; repeat (5) step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b exp 1", done); end
    n_checks++; if (trig_addr !== 32'd12) begin n_fail++; $display("FAIL wrap_trig_addr got %0d exp 12", trig_addr); end
    step();
    n_checks++;
    if (addr_q.size() - qb !== 9) begin
      n_fail++; $display("FAIL wrap_write_count got %0d exp 9", addr_q.size() - qb);
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (addr_q[qb + i] !== exp_a[i]) begin
          n_fail++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, addr_q[qb + i], exp_a[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_falling_gaps();
    test_pretrig_zero();
    test_continuous();
    test_reset_busy();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
